// File: rtl/mac_accum_pkg.sv
// Shared types, constants and carry-lookahead helpers for the streaming MAC accumulator.
package mac_accum_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  localparam int unsigned SliceW  = 16;
  localparam int unsigned DefAccW = 32;
  localparam int unsigned DefCntW = 8;

  // Carries into bit positions 0..3 of a 4-bit lookahead group.
  function automatic logic [3:0] cla4_c(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Group generate of a 4-bit lookahead group.
  function automatic logic cla4_g(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/mac_accum_16_if.sv
// Job control, input stream and result handshake of the MAC accumulator.
interface mac_accum_16_if #(
  parameter int unsigned AccW = mac_accum_pkg::DefAccW,
  parameter int unsigned CntW = mac_accum_pkg::DefCntW
);

  logic                             start;
  logic [CntW-1:0]                  len;
  logic                             in_valid;
  logic                             in_ready;
  logic [mac_accum_pkg::SliceW-1:0] in_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [AccW-1:0]                  out_data;
  logic                             out_ovf;
  logic                             busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );

endinterface

// File: rtl/mac_accum_16_cla.sv
// 16-bit two-level carry-lookahead adder slice (four 4-bit groups).
module mac_accum_16_cla
  import mac_accum_pkg::*;
(
  input  logic [SliceW-1:0] a_i,
  input  logic [SliceW-1:0] b_i,
  input  logic              cin_i,
  output logic [SliceW-1:0] sum_o,
  output logic              cout_o
);

  logic [SliceW-1:0] g, p, c;
  logic [3:0]        gg, gp, gcin;

  // Bit generate/propagate, group lookahead, then per-bit carries from group carry-ins.
  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;
    for (int k = 0; k < 4; k++) begin
      gg[k] = cla4_g(g[4*k +: 4], p[4*k +: 4]);
      gp[k] = &p[4*k +: 4];
    end
    gcin = cla4_c(gg, gp, cin_i);
    for (int k = 0; k < 4; k++) begin
      c[4*k +: 4] = cla4_c(g[4*k +: 4], p[4*k +: 4], gcin[k]);
    end
    sum_o  = p ^ c;
    cout_o = cla4_g(gg, gp) | (&gp & cin_i);
  end

endmodule

// File: rtl/mac_accum_16.sv
// Streaming signed accumulator: sums len sign-extended 16-bit terms, then offers the result.
module mac_accum_16
  import mac_accum_pkg::*;
#(
  parameter int unsigned AccW = DefAccW,
  parameter int unsigned CntW = DefCntW
) (
  input  logic         clk,
  input  logic         rst,
  mac_accum_16_if.slave bus
);

  localparam int unsigned NumSlices = AccW / SliceW;

  state_e            state_q, state_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [AccW-1:0]   addend, sum;
  logic [NumSlices:0] carry;
  logic              add_ovf;
  logic              unused_cout;

  assign addend   = AccW'($signed(bus.in_data));
  assign carry[0] = 1'b0;
  // The final carry-out carries no information for a wrapping two's-complement sum.
  assign unused_cout = carry[NumSlices];

  for (genvar s = 0; s < NumSlices; s++) begin : g_slice
    mac_accum_16_cla u_cla (
      .a_i   (acc_q[s*SliceW +: SliceW]),
      .b_i   (addend[s*SliceW +: SliceW]),
      .cin_i (carry[s]),
      .sum_o (sum[s*SliceW +: SliceW]),
      .cout_o(carry[s+1])
    );
  end

  // Signed overflow: like-signed addends yielding a sum of the opposite sign.
  assign add_ovf = (acc_q[AccW-1] == addend[AccW-1]) && (sum[AccW-1] != acc_q[AccW-1]);

  // Handshake outputs decode from registered state only.
  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = ovf_q;

  // Next-state logic: job start, term accumulation, result handoff.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = bus.len;
          state_d = (bus.len == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (bus.in_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accum_16.sv
// Bench for mac_accum_16: a 32-bit and a 16-bit instance driven in lockstep, scoreboarded.
module tb_mac_accum_16;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] stim_q[$];
  exp_t        exp32_q[$];
  exp_t        exp16_q[$];

  mac_accum_16_if #(.AccW(32), .CntW(8)) bus ();
  mac_accum_16_if #(.AccW(16), .CntW(8)) bus16 ();

  assign bus.start       = start;
  assign bus.len         = len;
  assign bus.in_valid    = in_valid;
  assign bus.in_data     = in_data;
  assign bus.out_ready   = out_ready;
  assign bus16.start     = start;
  assign bus16.len       = len;
  assign bus16.in_valid  = in_valid;
  assign bus16.in_data   = in_data;
  assign bus16.out_ready = out_ready;

  mac_accum_16 #(.AccW(32), .CntW(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  mac_accum_16 #(.AccW(16), .CntW(8)) dut16 (
    .clk(clk),
    .rst(rst),
    .bus(bus16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Reference: wrapping w-bit sum of sign-extended terms with sticky signed overflow.
  function automatic exp_t model(input int w);
    exp_t        e;
    logic [31:0] mask, acc, b, s;
    mask  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    acc   = '0;
    e.ovf = 1'b0;
    foreach (stim_q[i]) begin
      b = {{16{stim_q[i][15]}}, stim_q[i]} & mask;
      s = (acc + b) & mask;
      if ((acc[w-1] == b[w-1]) && (s[w-1] != acc[w-1])) e.ovf = 1'b1;
      acc = s;
    end
    e.data = acc;
    return e;
  endfunction

  // Runs one job from stim_q with `gap` idle cycles before each term and `hold` cycles of
  // output backpressure (with start pulses), then completes the handshake.
  task automatic run_job(input string name, input int gap, input int hold,
                         output logic [31:0] d32, output logic o32,
                         output logic [15:0] d16, output logic o16);
    exp_t e32, e16;
    int   n;
    n = stim_q.size();
    exp32_q.push_back(model(32));
    exp16_q.push_back(model(16));
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    sample();
    n_checks++;
    if (bus.in_ready !== (n != 0) || bus.out_valid !== (n == 0))
      $display("FAIL %s start_decode: in_ready=%b out_valid=%b want %b %b",
               name, bus.in_ready, bus.out_valid, n != 0, n == 0);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < gap; k++) begin
        in_valid = 1'b0;
        tick();
        sample();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
          $display("FAIL %s gap_hold: in_ready=%b out_valid=%b want 1 0",
                   name, bus.in_ready, bus.out_valid);
        else n_pass++;
      end
      in_valid = 1'b1;
      in_data  = stim_q[i];
      tick();
    end
    in_valid = 1'b0;
    if (n != 0) begin
      sample();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        $display("FAIL %s done_latency: out_valid=%b in_ready=%b want 1 0",
                 name, bus.out_valid, bus.in_ready);
      else n_pass++;
    end
    e32 = exp32_q.pop_front();
    e16 = exp16_q.pop_front();
    d32 = bus.out_data;
    o32 = bus.out_ovf;
    d16 = bus16.out_data;
    o16 = bus16.out_ovf;
    n_checks++;
    if (bus.out_data !== e32.data || bus.out_ovf !== e32.ovf)
      $display("FAIL %s result32: got %h/%b want %h/%b",
               name, bus.out_data, bus.out_ovf, e32.data, e32.ovf);
    else n_pass++;
    n_checks++;
    if (bus16.out_data !== e16.data[15:0] || bus16.out_ovf !== e16.ovf)
      $display("FAIL %s result16: got %h/%b want %h/%b",
               name, bus16.out_data, bus16.out_ovf, e16.data[15:0], e16.ovf);
    else n_pass++;
    for (int k = 0; k < hold; k++) begin
      start = 1'b1;
      len   = 8'd5;
      tick();
      sample();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e32.data || bus.out_ovf !== e32.ovf ||
          bus.in_ready !== 1'b0)
        $display("FAIL %s backpressure_hold: valid=%b data=%h ovf=%b in_ready=%b want 1 %h %b 0",
                 name, bus.out_valid, bus.out_data, bus.out_ovf, bus.in_ready, e32.data, e32.ovf);
      else n_pass++;
    end
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd3;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    sample();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 ||
        bus16.busy !== 1'b0)
      $display("FAIL %s handshake_idle: valid=%b in_ready=%b busy=%b busy16=%b want 0 0 0 0",
               name, bus.out_valid, bus.in_ready, bus.busy, bus16.busy);
    else n_pass++;
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 ||
        bus.out_ovf !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL %s: in_ready=%b valid=%b data=%h ovf=%b busy=%b want 0 0 0 0 0",
               name, bus.in_ready, bus.out_valid, bus.out_data, bus.out_ovf, bus.busy);
    else n_pass++;
    n_checks++;
    if (bus16.out_data !== 16'h0 || bus16.out_ovf !== 1'b0 || bus16.busy !== 1'b0)
      $display("FAIL %s16: data=%h ovf=%b busy=%b want 0 0 0",
               name, bus16.out_data, bus16.out_ovf, bus16.busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    repeat (2) tick();
    sample();
    check_idle_outputs("reset_state");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] d32;
    logic [15:0] d16;
    logic        o32, o16;
    stim_q = {16'd1, 16'd2, 16'd3, 16'd4};
    run_job("basic", 0, 0, d32, o32, d16, o16);
    n_checks++;
    if (d32 !== 32'h0000_000A || o32 !== 1'b0)
      $display("FAIL basic_const: got %h/%b want 0000000a/0", d32, o32);
    else n_pass++;
  endtask

  task automatic test_negative();
    logic [31:0] d32;
    logic [15:0] d16;
    logic        o32, o16;
    stim_q = {16'h8000, 16'h8000, 16'h0001};
    run_job("negative", 0, 0, d32, o32, d16, o16);
    n_checks++;
    if (d32 !== 32'hFFFF_0001 || o32 !== 1'b0)
      $display("FAIL negative_const: got %h/%b want ffff0001/0", d32, o32);
    else n_pass++;
  endtask

  task automatic test_carry();
    logic [31:0] d32;
    logic [15:0] d16;
    logic        o32, o16;
    stim_q = {16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_job("carry", 0, 0, d32, o32, d16, o16);
    n_checks++;
    if (d32 !== 32'h0001_7FFD)
      $display("FAIL carry_const: got %h want 00017ffd", d32);
    else n_pass++;
  endtask

  task automatic test_len0();
    logic [31:0] d32;
    logic [15:0] d16;
    logic        o32, o16;
    stim_q = {};
    run_job("len0", 0, 0, d32, o32, d16, o16);
    n_checks++;
    if (d32 !== 32'h0 || o32 !== 1'b0)
      $display("FAIL len0_const: got %h/%b want 00000000/0", d32, o32);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] d32;
    logic [15:0] d16;
    logic        o32, o16;
    stim_q = {16'h1234, 16'hFFFE};
    run_job("stall", 3, 0, d32, o32, d16, o16);
    n_checks++;
    if (d32 !== 32'h0000_1232)
      $display("FAIL stall_const: got %h want 00001232", d32);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d32;
    logic [15:0] d16;
    logic        o32, o16;
    stim_q = {16'h0005, 16'hFFF0};
    run_job("backpressure", 0, 5, d32, o32, d16, o16);
    n_checks++;
    if (d32 !== 32'hFFFF_FFF5)
      $display("FAIL backpressure_const: got %h want fffffff5", d32);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] d32;
    logic [15:0] d16;
    logic        o32, o16;
    stim_q = {16'h7FFF, 16'h0001};
    run_job("overflow", 0, 0, d32, o32, d16, o16);
    n_checks++;
    if (d16 !== 16'h8000 || o16 !== 1'b1 || d32 !== 32'h0000_8000 || o32 !== 1'b0)
      $display("FAIL overflow_const: got16 %h/%b got32 %h/%b want 8000/1 00008000/0",
               d16, o16, d32, o32);
    else n_pass++;
    // Sum re-enters range but the flag must stay set.
    stim_q = {16'h7FFF, 16'h0001, 16'hFFFF};
    run_job("ovf_sticky", 1, 0, d32, o32, d16, o16);
    n_checks++;
    if (d16 !== 16'h7FFF || o16 !== 1'b1)
      $display("FAIL ovf_sticky_const: got %h/%b want 7fff/1", d16, o16);
    else n_pass++;
    stim_q = {16'h0001};
    run_job("ovf_cleared", 0, 0, d32, o32, d16, o16);
    n_checks++;
    if (d16 !== 16'h0001 || o16 !== 1'b0)
      $display("FAIL ovf_cleared_const: got %h/%b want 0001/0", d16, o16);
    else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] d32;
    logic [15:0] d16;
    logic        o32, o16;
    start = 1'b1;
    len   = 8'd3;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0100;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    check_idle_outputs("reset_mid_job");
    for (int k = 0; k < 4; k++) begin
      tick();
      sample();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL reset_no_output: valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
      else n_pass++;
    end
    stim_q = {16'h0003, 16'hFFFF};
    run_job("after_reset", 0, 0, d32, o32, d16, o16);
    n_checks++;
    if (d32 !== 32'h0000_0002)
      $display("FAIL after_reset_const: got %h want 00000002", d32);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_carry();
    test_len0();
    test_stall();
    test_backpressure();
    test_overflow();
    test_reset_mid_job();
    n_checks++;
    if (exp32_q.size() != 0 || exp16_q.size() != 0)
      $display("FAIL scoreboard_drain: %0d/%0d entries left want 0",
               exp32_q.size(), exp16_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
